// File: rtl/mesi_isc_breq_arb.sv
// MESI ISC broadcast-request front end: round-robin capture of
// WR_BROAD/RD_BROAD requests from four CPU ports into a shared queue.
module mesi_isc_breq_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4*MBUS_CMD_WIDTH-1:0]     mbus_cmd_i,
  input  logic [4*ADDR_WIDTH-1:0]         mbus_addr_i,
  output logic [3:0]                      mbus_ack_o,
  output logic                            breq_valid_o,
  input  logic                            breq_ready_i,
  output logic [1:0]                      breq_id_o,
  output logic [MBUS_CMD_WIDTH-1:0]       breq_cmd_o,
  output logic [ADDR_WIDTH-1:0]           breq_addr_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            fifo_full_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR_BROAD =
    MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD =
    MBUS_CMD_WIDTH'(4);

  logic [MBUS_CMD_WIDTH-1:0] cmd_a [4];
  logic [ADDR_WIDTH-1:0]     addr_a [4];

  logic [3:0]    ack_q, ack_d;
  logic [1:0]    rr_q, rr_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]                id_mem   [FIFO_DEPTH];
  logic [MBUS_CMD_WIDTH-1:0] cmd_mem  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     addr_mem [FIFO_DEPTH];

  logic [3:0] req;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = mbus_cmd_i[p*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      addr_a[p] = mbus_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // A port still holding its command in the ack cycle is masked,
  // so each held request yields exactly one queue entry.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      req[p] = ((cmd_a[p] == CMD_WR_BROAD) ||
                (cmd_a[p] == CMD_RD_BROAD)) && !ack_q[p];
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && breq_ready_i;
  assign push  = (|req) && (!full || pop);

  // Search starts one past the last grant and wraps 3 -> 0.
  always_comb begin
    win   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ack_d = 4'b0000;
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      ack_d = 4'b0001 << win;
      rr_d  = win;
      wr_d  = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 4'b0000;
      rr_q  <= 2'd3;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: head fields are gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_q]   <= win;
      cmd_mem[wr_q]  <= cmd_a[win];
      addr_mem[wr_q] <= addr_a[win];
    end
  end

  assign mbus_ack_o   = ack_q;
  assign breq_valid_o = !empty;
  assign breq_id_o    = empty ? '0 : id_mem[rd_q];
  assign breq_cmd_o   = empty ? '0 : cmd_mem[rd_q];
  assign breq_addr_o  = empty ? '0 : addr_mem[rd_q];
  assign fifo_count_o = cnt_q;
  assign fifo_full_o  = full;

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Bench for mesi_isc_breq_arb: vector table, directed corner
// sequences and randomized traffic against a queue-based model.
module tb_mesi_isc_breq_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  cmd;
  logic [127:0] addr;
  logic [3:0]   ack;
  logic         valid;
  logic         ready;
  logic [1:0]   id;
  logic [2:0]   hcmd;
  logic [31:0]  haddr;
  logic [2:0]   cnt;
  logic         full;

  int total = 0;
  int bad   = 0;

  mesi_isc_breq_arb dut (
    .clk          (clk),
    .rst          (rst),
    .mbus_cmd_i   (cmd),
    .mbus_addr_i  (addr),
    .mbus_ack_o   (ack),
    .breq_valid_o (valid),
    .breq_ready_i (ready),
    .breq_id_o    (id),
    .breq_cmd_o   (hcmd),
    .breq_addr_o  (haddr),
    .fifo_count_o (cnt),
    .fifo_full_o  (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [2:0]  cmd;
    logic [31:0] addr;
  } ent_t;

  typedef struct packed {
    logic [11:0] cmds;
    logic [3:0]  ack;
    logic        v;
    logic [1:0]  id;
    logic [31:0] a;
    logic [2:0]  cnt;
  } vec_t;

  ent_t       m_q[$];
  logic [3:0] m_ack;
  int         m_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [2:0] c,
                          input logic [31:0] a);
    cmd[p*3 +: 3]   = c;
    addr[p*32 +: 32] = a;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ack"}, 32'(ack), 32'd0);
    chk({nm, ".valid"}, 32'(valid), 32'd0);
    chk({nm, ".id"}, 32'(id), 32'd0);
    chk({nm, ".cmd"}, 32'(hcmd), 32'd0);
    chk({nm, ".addr"}, haddr, 32'd0);
    chk({nm, ".cnt"}, 32'(cnt), 32'd0);
    chk({nm, ".full"}, 32'(full), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd = '0;
    ready = 1'b0;
    at_neg();
    at_neg();
    rst = 1'b1;
    at_neg();
  endtask

  task automatic model_step();
    logic [3:0] r;
    logic [2:0] c;
    bit         pop;
    int         win;
    int         p;
    for (int i = 0; i < 4; i++) begin
      c = cmd[i*3 +: 3];
      r[i] = (c == 3'd3 || c == 3'd4) && !m_ack[i];
    end
    pop = (m_q.size() != 0) && ready;
    win = -1;
    if (r != 0 && (m_q.size() < 4 || pop)) begin
      for (int k = 1; k <= 4; k++) begin
        p = (m_last + k) % 4;
        if (win < 0 && r[p]) win = p;
      end
    end
    if (pop) void'(m_q.pop_front());
    m_ack = 4'b0000;
    if (win >= 0) begin
      m_q.push_back('{id: 2'(win), cmd: cmd[win*3 +: 3],
                      addr: addr[win*32 +: 32]});
      m_ack[win] = 1'b1;
      m_last = win;
    end
  endtask

  vec_t vt [9];

  initial begin
    rst = 1'b0;
    cmd = '0;
    addr = '0;
    ready = 1'b0;

    // reset held with random inputs, then released with NOPs
    for (int i = 0; i < 3; i++) begin
      at_neg();
      cmd = 12'($urandom);
      addr = {$urandom, $urandom, $urandom, $urandom};
      ready = 1'($urandom);
      chk_zero("rst_hold");
    end
    at_neg();
    cmd = '0;
    ready = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("rel.valid", 32'(valid), 32'd0);
      chk("rel.cnt", 32'(cnt), 32'd0);
    end

    // round-robin over all four ports, ready held high
    vt[0] = '{12'o3333, 4'h0, 1'b0, 2'd0, 32'h0, 3'd0};
    vt[1] = '{12'o3333, 4'h1, 1'b1, 2'd0, 32'h0, 3'd1};
    vt[2] = '{12'o3330, 4'h2, 1'b1, 2'd1, 32'h4, 3'd1};
    vt[3] = '{12'o3300, 4'h4, 1'b1, 2'd2, 32'h8, 3'd1};
    vt[4] = '{12'o3000, 4'h8, 1'b1, 2'd3, 32'hC, 3'd1};
    vt[5] = '{12'o3003, 4'h0, 1'b0, 2'd0, 32'h0, 3'd0};
    vt[6] = '{12'o3003, 4'h1, 1'b1, 2'd0, 32'h0, 3'd1};
    vt[7] = '{12'o3000, 4'h8, 1'b1, 2'd3, 32'hC, 3'd1};
    vt[8] = '{12'o0000, 4'h0, 1'b0, 2'd0, 32'h0, 3'd0};
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 3'd0, 32'(p * 4));
    for (int i = 0; i < 9; i++) begin
      at_neg();
      chk($sformatf("vec%0d.ack", i), 32'(ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vt[i].v));
      chk($sformatf("vec%0d.cnt", i), 32'(cnt), 32'(vt[i].cnt));
      if (vt[i].v) begin
        chk($sformatf("vec%0d.id", i), 32'(id), 32'(vt[i].id));
        chk($sformatf("vec%0d.cmd", i), 32'(hcmd), 32'd3);
        chk($sformatf("vec%0d.addr", i), haddr, vt[i].a);
      end
      cmd = vt[i].cmds;
      ready = 1'b1;
    end

    // single RD_BROAD held through its ack cycle
    do_reset();
    set_port(2, 3'd4, 32'h40);
    at_neg();
    chk("p2.ack", 32'(ack), 32'h4);
    chk("p2.valid", 32'(valid), 32'd1);
    chk("p2.id", 32'(id), 32'd2);
    chk("p2.cmd", 32'(hcmd), 32'd4);
    chk("p2.addr", haddr, 32'h40);
    chk("p2.cnt", 32'(cnt), 32'd1);
    at_neg();
    chk("p2.ack_off", 32'(ack), 32'h0);
    chk("p2.once", 32'(cnt), 32'd1);
    set_port(2, 3'd0, 32'h0);
    ready = 1'b1;
    at_neg();
    chk("p2.cnt0", 32'(cnt), 32'd0);
    chk("p2.valid0", 32'(valid), 32'd0);
    ready = 1'b0;

    // fill to full, fifth request waits for a pop
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 3'd3, 32'(p * 4));
    at_neg();
    chk("full.ack0", 32'(ack), 32'h1);
    set_port(0, 3'd0, 32'h0);
    at_neg();
    chk("full.ack1", 32'(ack), 32'h2);
    set_port(1, 3'd0, 32'h0);
    set_port(0, 3'd4, 32'h100);
    at_neg();
    chk("full.ack2", 32'(ack), 32'h4);
    set_port(2, 3'd0, 32'h0);
    at_neg();
    chk("full.ack3", 32'(ack), 32'h8);
    chk("full.cnt4", 32'(cnt), 32'd4);
    chk("full.flag", 32'(full), 32'd1);
    set_port(3, 3'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("full.stall_ack", 32'(ack), 32'h0);
      chk("full.stall_cnt", 32'(cnt), 32'd4);
    end
    chk("full.head", 32'(id), 32'd0);
    ready = 1'b1;
    at_neg();
    chk("full.swap_ack", 32'(ack), 32'h1);
    chk("full.swap_cnt", 32'(cnt), 32'd4);
    chk("full.swap_full", 32'(full), 32'd1);
    chk("full.swap_head", 32'(id), 32'd1);
    ready = 1'b0;
    set_port(0, 3'd0, 32'h0);
    at_neg();
    chk("full.after", 32'(ack), 32'h0);
    ready = 1'b1;
    at_neg();
    chk("mid.cnt3", 32'(cnt), 32'd3);
    chk("mid.head", 32'(id), 32'd2);
    ready = 1'b0;

    // asynchronous reset between clock edges with a request pending
    set_port(1, 3'd3, 32'h80);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async");
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("async.ack", 32'(ack), 32'h0);
      chk("async.cnt", 32'(cnt), 32'd0);
    end
    set_port(1, 3'd0, 32'h0);
    rst = 1'b1;
    at_neg();
    chk("async.rel_ack", 32'(ack), 32'h0);

    // non-broadcast codes are ignored
    do_reset();
    cmd = {3'd7, 3'd6, 3'd2, 3'd1};
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("nobc.ack", 32'(ack), 32'h0);
      chk("nobc.cnt", 32'(cnt), 32'd0);
      chk("nobc.valid", 32'(valid), 32'd0);
    end

    // randomized traffic against the model
    do_reset();
    m_q.delete();
    m_ack = 4'b0000;
    m_last = 3;
    for (int n = 0; n < 3000; n++) begin
      int pct;
      at_neg();
      chk("rnd.ack", 32'(ack), 32'(m_ack));
      chk("rnd.valid", 32'(valid), 32'(m_q.size() != 0));
      chk("rnd.cnt", 32'(cnt), 32'(m_q.size()));
      chk("rnd.full", 32'(full), 32'(m_q.size() == 4));
      if (m_q.size() != 0) begin
        chk("rnd.id", 32'(id), 32'(m_q[0].id));
        chk("rnd.cmd", 32'(hcmd), 32'(m_q[0].cmd));
        chk("rnd.addr", haddr, m_q[0].addr);
      end
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 1) == 0) begin
          if ($urandom_range(0, 2) != 0)
            set_port(p, 3'(3 + $urandom_range(0, 1)), $urandom);
          else
            set_port(p, 3'($urandom_range(0, 7)), $urandom);
        end
      end
      case ((n / 500) % 3)
        0:       pct = 20;
        1:       pct = 50;
        default: pct = 90;
      endcase
      ready = ($urandom_range(0, 99) < pct);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
